// File: rtl/diod_pkg.sv
// Shared definitions for the SPI DAC arbiter: FSM encodings, channel ids, default word width.
package diod_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERR       = 3'd5
  } state_e;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// Saturating timeout counter; hit fires in the cycle whose increment reaches limit.
module arb_timeout_counter #(
  parameter int TO_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] limit,
  output logic            hit
);

  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);
    hit     = en && (cnt_inc == limit);
    cnt_d   = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_inc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_dac_arbiter.sv
// Round-robin arbiter sharing one SPI DAC link between two requesters;
// one frame per grant, completion tracked from spi_ss, timeouts abort with err.
module spi_dac_arbiter
  import diod_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int START_TO = 15,
  parameter int FRAME_TO = 255,
  parameter int TO_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  input  logic              spi_ss,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data,
  output logic              busy,
  output logic              err,
  output logic [2:0]        debug_state
);

  state_e            state_q, state_d;
  ch_e               last_q, last_d, gid_q, gid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              start_q, start_d, ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err_q, err_d, busy_q, busy_d;
  logic              to_clr, to_en, to_hit;
  logic [TO_W-1:0]   to_limit;

  // Counter only runs while waiting on an ss edge; any other cycle reloads it.
  always_comb begin
    to_en    = (state_q == ST_WAIT_LOW  &&  spi_ss) ||
               (state_q == ST_WAIT_HIGH && !spi_ss);
    to_clr   = !to_en;
    to_limit = (state_q == ST_WAIT_LOW) ? TO_W'(START_TO) : TO_W'(FRAME_TO);
  end

  arb_timeout_counter #(.TO_W(TO_W)) u_to (
    .clk   (clk),
    .reset (reset),
    .clr   (to_clr),
    .en    (to_en),
    .limit (to_limit),
    .hit   (to_hit)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) gid_d = (last_q == CH0) ? CH1 : CH0;
          else              gid_d = req1 ? CH1 : CH0;
          data_d  = (gid_d == CH1) ? data1 : data0;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (!spi_ss)     state_d = ST_WAIT_HIGH;
        else if (to_hit) state_d = ST_ERR;
      end
      ST_WAIT_HIGH: begin
        if (spi_ss)      state_d = ST_DONE;
        else if (to_hit) state_d = ST_ERR;
      end
      // A failed channel also counts as served so the other one goes next.
      ST_DONE, ST_ERR: begin
        last_d  = gid_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    start_d = (state_d == ST_START);
    ack0_d  = (state_d == ST_DONE) && (gid_d == CH0);
    ack1_d  = (state_d == ST_DONE) && (gid_d == CH1);
    err_d   = (state_d == ST_ERR);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= CH1;
      gid_q   <= CH0;
      data_q  <= '0;
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      start_q <= start_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign spi_start   = start_q;
  assign spi_data    = data_q;
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_spi_dac_arbiter.sv
// Directed bench for spi_dac_arbiter with a simple spi_ss responder model.
module tb_spi_dac_arbiter;

  localparam int DW = 8;

  logic          clk, reset;
  logic          req0, req1, ack0, ack1;
  logic [DW-1:0] data0, data1, spi_data;
  logic          spi_ss = 1'b1;
  logic          spi_start, busy, err;
  logic [2:0]    debug_state;

  int n_cmp = 0;
  int n_bad = 0;
  int ss_mode = 0;   // 0: normal frame, 1: ss stuck high, 2: ss falls and sticks low
  int mcnt = -1;

  spi_dac_arbiter #(.DATA_W(DW), .START_TO(15), .FRAME_TO(255), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .spi_ss(spi_ss), .spi_start(spi_start), .spi_data(spi_data),
    .busy(busy), .err(err), .debug_state(debug_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // spi_module stand-in: ss low from start+2 for 16 cycles
  initial forever begin
    @(posedge clk); #1;
    if (reset || ss_mode == 1) begin
      spi_ss = 1'b1;
      mcnt   = -1;
    end else if (spi_start) begin
      mcnt = 0;
    end else if (mcnt >= 0) begin
      mcnt++;
      if (mcnt == 2) spi_ss = 1'b0;
      if (ss_mode == 0 && mcnt == 18) begin
        spi_ss = 1'b1;
        mcnt   = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the START cycle; returns in the ack cycle.
  task automatic serve(input string tag, input int ch, input logic [DW-1:0] d, input bit drop);
    int hits;
    chk({tag, ".start"}, 32'(spi_start), 32'd1);
    chk({tag, ".data"},  32'(spi_data), 32'(d));
    if (ch == 0) data0 = ~d; else data1 = ~d;
    hits = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      hits += int'(ack0) + int'(ack1) + int'(err);
    end
    chk({tag, ".early"}, 32'(hits), 32'd0);
    chk({tag, ".hold"},  32'(spi_data), 32'(d));
    tick();
    chk({tag, ".ack0"}, 32'(ack0), 32'(ch == 0));
    chk({tag, ".ack1"}, 32'(ack1), 32'(ch == 1));
    chk({tag, ".err"},  32'(err), 32'd0);
    if (ch == 0) data0 = d; else data1 = d;
    if (drop) begin
      if (ch == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int hits;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    tick(); tick();
    chk("rst.start", 32'(spi_start), 32'd0);
    chk("rst.data",  32'(spi_data), 32'd0);
    chk("rst.acks",  32'({ack0, ack1, err, busy}), 32'd0);
    chk("rst.state", 32'(debug_state), 32'd0);

    // 1: single ch0 frame
    reset = 1'b0;
    req0 = 1'b1; data0 = 8'hA5;
    tick();
    chk("t1.state", 32'(debug_state), 32'd1);
    serve("t1", 0, 8'hA5, 1'b1);
    tick();
    chk("t1.idle", 32'({busy, debug_state}), 32'd0);

    // 2: simultaneous requests after reset, ch0 first
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h10; data1 = 8'h20;
    tick();
    serve("t2a", 0, 8'h10, 1'b1);
    tick();
    chk("t2.idle", 32'(busy), 32'd0);
    tick();
    serve("t2b", 1, 8'h20, 1'b1);
    tick();

    // 3: both held, grants alternate with one idle cycle between frames
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h31; data1 = 8'h32;
    tick();
    for (int i = 0; i < 4; i++) begin
      serve($sformatf("t3.%0d", i), i % 2, (i % 2 == 0) ? 8'h31 : 8'h32, 1'b0);
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
      chk($sformatf("t3.gap%0d", i), 32'({busy, debug_state}), 32'd0);
      if (i < 3) tick();
    end

    // 4: ss stuck high -> start timeout, next grant to ch1
    ss_mode = 1;
    req0 = 1'b1; data0 = 8'h3C;
    tick();
    chk("t4.start", 32'(spi_start), 32'd1);
    hits = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 5) begin
        req1 = 1'b1; data1 = 8'h5A;
      end
      hits += int'(err) + int'(ack0) + int'(ack1);
    end
    chk("t4.early", 32'(hits), 32'd0);
    tick();
    chk("t4.err",   32'(err), 32'd1);
    chk("t4.noack", 32'({ack0, ack1}), 32'd0);
    chk("t4.st",    32'(debug_state), 32'd5);
    ss_mode = 0;
    tick();
    chk("t4.idle", 32'(debug_state), 32'd0);
    tick();
    serve("t4b", 1, 8'h5A, 1'b1);
    tick();
    tick();
    serve("t4c", 0, 8'h3C, 1'b1);
    tick();

    // 5: ss stuck low -> frame timeout, ch0 retried with same data
    ss_mode = 2;
    req0 = 1'b1; data0 = 8'h77;
    tick();
    tick(); tick(); tick();
    chk("t5.wh", 32'(debug_state), 32'd3);
    hits = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      hits += int'(err) + int'(ack0) + int'(ack1);
    end
    chk("t5.early", 32'(hits), 32'd0);
    tick();
    chk("t5.err",   32'(err), 32'd1);
    chk("t5.noack", 32'({ack0, ack1}), 32'd0);
    ss_mode = 1;
    tick();
    chk("t5.idle", 32'(debug_state), 32'd0);
    ss_mode = 0;
    tick();
    serve("t5b", 0, 8'h77, 1'b1);
    tick();

    // 6: async reset mid-frame, then ch0 wins contention again
    req0 = 1'b1; data0 = 8'h99;
    tick();
    tick(); tick(); tick(); tick();
    chk("t6.wh", 32'(debug_state), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6.state", 32'(debug_state), 32'd0);
    chk("t6.outs",  32'({spi_data, spi_start, busy, ack0, ack1, err}), 32'd0);
    req1 = 1'b1; data1 = 8'h66;
    tick();
    reset = 1'b0;
    tick();
    serve("t6a", 0, 8'h99, 1'b1);
    tick();
    tick();
    serve("t6b", 1, 8'h66, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_dac_arbiter.md
Name: spi_dac_arbiter

Overview:
- Shares the single 8-bit spi_module (DAC link) between two requesters: ch0 is the voltage-sweep counter, ch1 is the auxiliary threshold/bias source.
- Grants round-robin, launches one SPI frame per grant, and tracks frame completion from spi_ss.
- Returns a one-cycle ack to the served requester.
- Sits between the requesters and spi_module, replacing the direct counter-to-SPI start/data wiring.

Parameters:
DATA_W, 8, width of DAC data word per channel and to spi_module
START_TO, 15, max cycles in WAIT_LOW for spi_ss to fall after spi_start
FRAME_TO, 255, max cycles in WAIT_HIGH for spi_ss to rise (frame end)
TO_W, 8, timeout counter width; must hold max(START_TO, FRAME_TO)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  ch0 request level, held until ack0
data0  input  DATA_W  ch0 word, sampled at grant only
ack0  output  1  one-cycle pulse: ch0 frame completed
req1  input  1  ch1 request level, held until ack1
data1  input  DATA_W  ch1 word, sampled at grant only
ack1  output  1  one-cycle pulse: ch1 frame completed
spi_ss  input  1  SS from spi_module: low = frame in progress
spi_start  output  1  one-cycle start pulse to spi_module
spi_data  output  DATA_W  word to spi_module, stable from START through WAIT_HIGH
busy  output  1  high in every state except IDLE
err  output  1  one-cycle pulse on timeout abort
debug_state  output  3  current state encoding

Behaviour:
- Reset (async, active-high) forces all outputs to 0 (spi_data=0) and clears the timeout counter.
- Reset also forces state=IDLE and last_grant=1, so ch0 wins the first contention.
- spi_module shares the same reset.
- States and encodings: IDLE=0, START=1, WAIT_LOW=2, WAIT_HIGH=3, DONE=4, ERR=5. Codes 6 and 7 go to IDLE.
- IDLE:
  - Only req0 high: grant ch0. Only req1 high: grant ch1.
  - Both high: grant the channel != last_grant.
  - On grant, latch the granted data into spi_data and store grant_id; next state START.
  - No request: stay in IDLE.
- START (exactly 1 cycle): spi_start=1; clear the timeout counter; go to WAIT_LOW.
- WAIT_LOW:
  - spi_ss==0 → WAIT_HIGH, counter cleared.
  - Otherwise the counter increments; when it reaches START_TO → ERR.
- WAIT_HIGH:
  - spi_ss==1 → DONE.
  - Otherwise the counter increments; when it reaches FRAME_TO → ERR.
- DONE (1 cycle): assert ack of grant_id; last_grant=grant_id; go to IDLE.
- ERR (1 cycle): err=1; no ack; last_grant=grant_id so the other channel gets the next turn; go to IDLE.
  - The failed requester keeps req high and is retried later.
- Latency:
  - req sampled high in IDLE at cycle N → spi_start high in cycle N+1.
  - spi_ss rise seen in WAIT_HIGH at cycle M → ack in M+1 → IDLE in M+2.
- Handshake rules:
  - Requester must drop req in the cycle after ack, so the IDLE sample at M+2 sees it low.
  - A req held longer is treated as a new request.
- dataX changes while a frame is in flight are ignored; spi_data is never modified outside IDLE grant.
- req dropped mid-frame: the frame still completes and the ack is still pulsed (requester ignores it).
- ack0, ack1 and err are mutually exclusive; at most one of them is high in any cycle.
- Reset mid-frame aborts immediately with no ack. spi_module is reset simultaneously, so no partial frame is resumed.
- Counter arithmetic: unsigned TO_W bits, saturating. Compare uses ==.

Decomposition:
- Shared package (diod_pkg): state encodings, channel ids CH0=0 and CH1=1, DATA_W default.
- One natural sub-module: arb_timeout_counter (clear, enable, limit input, hit output, TO_W wide), instantiated once and reloaded with START_TO or FRAME_TO depending on state.

Test Plan:
1. Reset, then req0=1 with data0=0xA5; spi_ss model falls 2 cycles after spi_start and rises 16 cycles later → spi_start 1 cycle after req, spi_data=0xA5, ack0 pulse 1 cycle after the ss rise, ack1=0, err=0.
2. req0 and req1 both raised in the same cycle after reset (data0=0x10, data1=0x20) → ch0 frame (0x10) first, then ch1 (0x20); ack0 precedes ack1.
3. Both requests held and re-raised continuously for 4 frames → grants alternate 0,1,0,1 with no starvation; busy drops for exactly 1 IDLE cycle between frames.
4. spi_ss stuck high → err pulse START_TO+1 cycles after spi_start; no ack; with req1 pending, the next grant goes to ch1.
5. spi_ss stuck low after start → err after FRAME_TO cycles in WAIT_HIGH; state returns to IDLE; req0 retried later with the same data.
6. Reset asserted in WAIT_HIGH → outputs 0 and debug_state=0 immediately (async); after release with req0 and req1 high, ch0 is granted first.
